// File: rtl/logic_scan_pkg.sv
// Shared types and constants for the logic scan driver: FSM state encoding,
// settle-timer sizing and golden truth tables of the small test circuits.
// Golden tables are indexed by the input vector {A,B,C}; bit k is the output
// the circuit must produce for input value k.
package logic_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } scan_state_e;

    // Settle timer width; the settle time per vector is limited to 0..15 cycles.
    localparam int SETTLE_CNT_W = 4;
    localparam int SETTLE_MAX   = 15;

    // out = ~(A&B) | (B&C): only {A,B,C} = 3'b110 yields 0.
    localparam logic [7:0] CIRCUIT5_GOLDEN = 8'hBF;
    // Reference tables for the other bench circuits.
    localparam logic [7:0] AND3_GOLDEN     = 8'h80;
    localparam logic [7:0] OR3_GOLDEN      = 8'hFE;
    localparam logic [7:0] XOR3_GOLDEN     = 8'h96;
    localparam logic [7:0] MAJ3_GOLDEN     = 8'hE8;

    // Clamp a requested settle time into the range the timer can count.
    function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int cycles);
        logic [SETTLE_CNT_W-1:0] val;
        if (cycles > SETTLE_MAX) begin
            val = SETTLE_CNT_W'(SETTLE_MAX);
        end else if (cycles < 0) begin
            val = '0;
        end else begin
            val = SETTLE_CNT_W'(cycles);
        end
        return val;
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that measures the hold time of one scan vector.
// The count is loaded on the edge that launches a vector; while enabled it
// counts down, and expire marks the last settle cycle so the controller
// moves to sampling on the following edge.
module scan_settle_timer
    import logic_scan_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    input  logic                    en,
    output logic                    expire
);

    logic [SETTLE_CNT_W-1:0] cnt;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A count of one (or zero, defensively) means this is the final settle cycle.
    assign expire = en && (cnt <= SETTLE_CNT_W'(1));

endmodule

// File: rtl/logic_scan_driver.sv
// logic_scan_driver: exhaustive truth-table scanner for a small combinational
// circuit. On start it drives every input vector in ascending order, holds each
// one for SETTLE_CYCLES extra cycles, samples the circuit output into table_q
// and grades the captured table against the golden mask latched at start.
// Every output comes straight from a register.
module logic_scan_driver
    import logic_scan_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2**N_IN-1:0]    expected,
    output logic [N_IN-1:0]       stim,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    table_q,
    output logic                  pass,
    output logic [N_IN:0]         mismatch_count,
    output logic                  first_fail_valid,
    output logic [N_IN-1:0]       first_fail_idx
);

    localparam int                      TBL_W      = 2**N_IN;
    localparam logic [N_IN-1:0]         IDX_MAX    = '1;
    localparam bit                      NO_SETTLE  = (SETTLE_CYCLES == 0);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_VAL = settle_load(SETTLE_CYCLES);

    scan_state_e        state;
    scan_state_e        state_nxt;

    // Current vector index; it doubles as the stimulus register.
    logic [N_IN-1:0]    idx;
    // Golden mask captured when the scan is accepted.
    logic [TBL_W-1:0]   exp_q;
    // Captured table with the current sample merged in.
    logic [TBL_W-1:0]   table_nxt;
    logic               vec_miss;

    // FSM control strobes.
    logic               accept;
    logic               sample_en;
    logic               last_vec;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_expire;

    scan_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_VAL),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one SETTLE stretch plus one SAMPLE cycle per vector.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_expire) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (idx == IDX_MAX) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: control strobes for the datapath and settle timer.
    always_comb begin
        accept    = 1'b0;
        sample_en = 1'b0;
        last_vec  = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                accept   = start;
                tmr_load = start;
            end
            S_SETTLE: begin
                tmr_en = 1'b1;
            end
            S_SAMPLE: begin
                sample_en = 1'b1;
                last_vec  = (idx == IDX_MAX);
                tmr_load  = (idx != IDX_MAX);
            end
            default: begin
            end
        endcase
    end

    // Merge the sampled output into the table and flag disagreement with the golden bit.
    always_comb begin
        table_nxt      = table_q;
        table_nxt[idx] = dut_out;
        vec_miss       = (dut_out != exp_q[idx]);
    end

    // Golden mask is plain data: it only needs to be valid once a scan is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            exp_q <= expected;
        end
    end

    // Scan datapath: vector stepping, capture, grading and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            table_q          <= '0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx              <= '0;
                busy             <= 1'b1;
                table_q          <= '0;
                pass             <= 1'b0;
                mismatch_count   <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
            end else if (sample_en) begin
                table_q <= table_nxt;
                if (vec_miss) begin
                    mismatch_count <= mismatch_count + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                end
                if (last_vec) begin
                    // Final vector: results become valid and the inputs park at zero.
                    idx  <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (table_nxt == exp_q);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign stim = idx;

endmodule
